// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet drain arbiter.
package pkt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    OUT     = 2'd2
  } arb_state_t;

  localparam logic SRC_VALID   = 1'b0;
  localparam logic SRC_INVALID = 1'b1;
  localparam int   WCNT_W      = 4;

endpackage

// File: rtl/pkt_arb_wrr.sv
// Weighted round-robin grant between the valid and invalid packet FIFOs.
// Grant is combinational from the empty flags; the weight counter advances on each grant.
module pkt_arb_wrr #(
  parameter int VALID_WEIGHT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       grant_stb,
  input  logic       drain_en,
  input  logic       vf_empty,
  input  logic       if_empty,
  output logic [1:0] grant
);
  import pkt_arb_pkg::*;

  localparam logic [WCNT_W-1:0] WEIGHT = WCNT_W'(VALID_WEIGHT);

  logic [WCNT_W-1:0] wcnt;

  // grant[0] selects the valid FIFO, grant[1] the invalid FIFO
  always_comb begin
    grant = 2'b00;
    if (grant_stb && drain_en) begin
      if (!vf_empty && !if_empty)
        grant = (wcnt < WEIGHT) ? 2'b01 : 2'b10;
      else if (!vf_empty)
        grant = 2'b01;
      else if (!if_empty)
        grant = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wcnt <= '0;
    else if (grant[1])
      wcnt <= '0;
    else if (grant[0] && (wcnt < WEIGHT))
      wcnt <= wcnt + 1'b1;
  end

endmodule

// File: rtl/pkt_drain_arbiter.sv
// Drains valid/invalid packet FIFOs into one tagged stream; rd_en to m_valid is 2 cycles, one word per 3 cycles.
// m_valid holds until m_ready; PKT_ARB_CNT_EN adds per-source handshake counters with cnt_clr.
module pkt_drain_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int VALID_WEIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic [DATA_WIDTH-1:0] vf_rd_data,
  input  logic                  vf_empty,
  output logic                  vf_rd_en,
  input  logic [DATA_WIDTH-1:0] if_rd_data,
  input  logic                  if_empty,
  output logic                  if_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_src,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef PKT_ARB_CNT_EN
  ,input  logic                 cnt_clr
  ,output logic [15:0]          vf_cnt
  ,output logic [15:0]          if_cnt
`endif
);
  import pkt_arb_pkg::*;

  arb_state_t state, state_nxt;
  logic [1:0] grant;
  logic       grant_stb;
  logic       gnt_src_q;

  // Reset also masks the combinational grant so no pop escapes while rst is high
  assign grant_stb = (state == IDLE) && !rst;

  pkt_arb_wrr #(
    .VALID_WEIGHT(VALID_WEIGHT)
  ) u_wrr (
    .clk      (clk),
    .rst      (rst),
    .grant_stb(grant_stb),
    .drain_en (drain_en),
    .vf_empty (vf_empty),
    .if_empty (if_empty),
    .grant    (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant != 2'b00) state_nxt = CAPTURE;
      CAPTURE: state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vf_rd_en = grant[0];
    if_rd_en = grant[1];
    m_valid  = (state == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_src_q <= SRC_VALID;
      m_data    <= '0;
      m_src     <= SRC_VALID;
    end else begin
      if (grant != 2'b00)
        gnt_src_q <= grant[1] ? SRC_INVALID : SRC_VALID;
      if (state == CAPTURE) begin
        m_data <= (gnt_src_q == SRC_INVALID) ? if_rd_data : vf_rd_data;
        m_src  <= gnt_src_q;
      end
    end
  end

`ifdef PKT_ARB_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vf_cnt <= '0;
      if_cnt <= '0;
    end else if (cnt_clr) begin
      vf_cnt <= '0;
      if_cnt <= '0;
    end else if (m_valid && m_ready) begin
      if (m_src == SRC_INVALID) begin
        if (if_cnt != 16'hFFFF) if_cnt <= if_cnt + 16'd1;
      end else begin
        if (vf_cnt != 16'hFFFF) vf_cnt <= vf_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pkt_drain_arbiter.sv
// Directed bench for pkt_drain_arbiter: FIFO models feed the DUT, a forked monitor scores every output word.
module tb_pkt_drain_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        drain_en;
  logic [31:0] vf_rd_data;
  logic        vf_empty;
  logic        vf_rd_en;
  logic [31:0] if_rd_data;
  logic        if_empty;
  logic        if_rd_en;
  logic [31:0] m_data;
  logic        m_src;
  logic        m_valid;
  logic        m_ready;
`ifdef PKT_ARB_CNT_EN
  logic        cnt_clr;
  logic [15:0] vf_cnt;
  logic [15:0] if_cnt;
`endif

  pkt_drain_arbiter #(.DATA_WIDTH(32), .VALID_WEIGHT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .drain_en  (drain_en),
    .vf_rd_data(vf_rd_data),
    .vf_empty  (vf_empty),
    .vf_rd_en  (vf_rd_en),
    .if_rd_data(if_rd_data),
    .if_empty  (if_empty),
    .if_rd_en  (if_rd_en),
    .m_data    (m_data),
    .m_src     (m_src),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
`ifdef PKT_ARB_CNT_EN
    ,.cnt_clr  (cnt_clr)
    ,.vf_cnt   (vf_cnt)
    ,.if_cnt   (if_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] vq[$];
  logic [31:0] iq[$];
  logic [32:0] sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rd = -100;
  int rd_pulses = 0;
  int if_pulses = 0;
  int hs_count = 0;
  logic last_pv, last_pi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // One clock: sample pops before the edge, apply them to the FIFO models just after it
  task automatic step();
    logic pv, pi;
    @(negedge clk);
    pv = vf_rd_en;
    pi = if_rd_en;
    @(posedge clk);
    #1;
    if (pv && vq.size() > 0) vf_rd_data = vq.pop_front();
    if (pi && iq.size() > 0) if_rd_data = iq.pop_front();
    vf_empty = (vq.size() == 0);
    if_empty = (iq.size() == 0);
    last_pv = pv;
    last_pi = pi;
  endtask

  task automatic push_v(input logic [31:0] d);
    vq.push_back(d);
    vf_empty = 1'b0;
    sb.push_back({1'b0, d});
  endtask

  task automatic load_v(input logic [31:0] d);
    vq.push_back(d);
    vf_empty = 1'b0;
  endtask

  task automatic load_i(input logic [31:0] d);
    iq.push_back(d);
    if_empty = 1'b0;
  endtask

  task automatic expect_word(input logic src, input logic [31:0] d);
    sb.push_back({src, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vq.delete();
    iq.delete();
    vf_empty = 1'b1;
    if_empty = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeout(name);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!m_valid && n < budget) begin
      step();
      n++;
    end
    if (!m_valid) timeout(name);
  endtask

  task automatic monitor();
    logic prev_v;
    logic [32:0] exp_w;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (vf_rd_en || if_rd_en) begin
        rd_pulses++;
        last_rd = cyc;
        check("rd_en_exclusive", 64'(vf_rd_en & if_rd_en), 64'd0);
        check("rd_en_while_empty", 64'((vf_rd_en & vf_empty) | (if_rd_en & if_empty)), 64'd0);
      end
      if (if_rd_en) if_pulses++;
      if (m_valid && !prev_v) check("rd_to_valid_latency", 64'(cyc - last_rd), 64'd2);
      prev_v = m_valid;
      if (m_valid && m_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got word %h src %0d, none expected", m_data, m_src);
        end else begin
          exp_w = sb.pop_front();
          check("out_data", 64'(m_data), 64'(exp_w[31:0]));
          check("out_src", 64'(m_src), 64'(exp_w[32]));
        end
      end
    end
  endtask

  initial begin
    int rp0, ip0, hs0, nv;
    rst = 1'b1;
    drain_en = 1'b0;
    m_ready = 1'b0;
    vf_empty = 1'b1;
    if_empty = 1'b1;
    vf_rd_data = '0;
    if_rd_data = '0;
    last_pv = 1'b0;
    last_pi = 1'b0;
`ifdef PKT_ARB_CNT_EN
    cnt_clr = 1'b0;
`endif
    fork
      monitor();
    join_none

    // Reset state
    #12;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_vf_rd_en", 64'(vf_rd_en), 64'd0);
    check("rst_if_rd_en", 64'(if_rd_en), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_src", 64'(m_src), 64'd0);
    step();
    rst = 1'b0;

    // Only the valid FIFO holds data
    ip0 = if_pulses;
    push_v(32'hA500_0001);
    push_v(32'hA500_0002);
    drain_en = 1'b1;
    m_ready = 1'b1;
    wait_drain("valid_only_drain", 40);
    check("valid_only_no_if_rd", 64'(if_pulses - ip0), 64'd0);

    // Both FIFOs hold 8 words: V,V,V,I pattern until valid empties
    do_reset();
    for (int k = 0; k < 8; k++) load_v(32'hB000_0000 + 32'(k));
    for (int k = 0; k < 8; k++) load_i(32'hC000_0000 + 32'(k));
    for (int k = 0; k < 3; k++) expect_word(1'b0, 32'hB000_0000 + 32'(k));
    expect_word(1'b1, 32'hC000_0000);
    for (int k = 3; k < 6; k++) expect_word(1'b0, 32'hB000_0000 + 32'(k));
    expect_word(1'b1, 32'hC000_0001);
    expect_word(1'b0, 32'hB000_0006);
    expect_word(1'b0, 32'hB000_0007);
    for (int k = 2; k < 8; k++) expect_word(1'b1, 32'hC000_0000 + 32'(k));
    wait_drain("wrr_drain", 200);
    check("wrr_all_consumed", 64'(vq.size() + iq.size()), 64'd0);

    // Backpressure: hold m_ready low for 10 cycles in OUT
    do_reset();
    m_ready = 1'b0;
    push_v(32'hD000_0001);
    wait_valid("bp_wait_valid", 10);
    rp0 = rd_pulses;
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_valid_held", 64'(m_valid), 64'd1);
      check("bp_data_held", 64'(m_data), 64'hD000_0001);
      check("bp_src_held", 64'(m_src), 64'd0);
    end
    check("bp_no_rd_en", 64'(rd_pulses - rp0), 64'd0);
    hs0 = hs_count;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    step();
    step();
    check("bp_one_handshake", 64'(hs_count - hs0), 64'd1);
    check("bp_valid_dropped", 64'(m_valid), 64'd0);

    // drain_en dropped during CAPTURE of the second valid word; wcnt must survive
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) load_v(32'hE000_0000 + 32'(k));
    load_i(32'hF000_0000);
    expect_word(1'b0, 32'hE000_0000);
    expect_word(1'b0, 32'hE000_0001);
    expect_word(1'b0, 32'hE000_0002);
    expect_word(1'b1, 32'hF000_0000);
    expect_word(1'b0, 32'hE000_0003);
    nv = 0;
    for (int k = 0; k < 40 && nv < 2; k++) begin
      step();
      if (last_pv) nv++;
    end
    if (nv < 2) timeout("gate_wait_grants");
    drain_en = 1'b0;
    rp0 = rd_pulses;
    for (int k = 0; k < 12; k++) step();
    check("gate_no_rd_en", 64'(rd_pulses - rp0), 64'd0);
    check("gate_word_completed", 64'(sb.size()), 64'd3);
    drain_en = 1'b1;
    wait_drain("gate_resume_drain", 60);

    // Async reset while a word is held in OUT
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) load_v(32'h1000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) load_i(32'h2000_0000 + 32'(k));
    expect_word(1'b0, 32'h1000_0000);
    wait_valid("arst_wait_valid", 10);
    #2;
    rst = 1'b1;
    #1;
    check("arst_m_valid", 64'(m_valid), 64'd0);
    check("arst_rd_en", 64'({vf_rd_en, if_rd_en}), 64'd0);
    void'(sb.pop_front());
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k < 4; k++) expect_word(1'b0, 32'h1000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) expect_word(1'b1, 32'h2000_0000 + 32'(k));
    m_ready = 1'b1;
    wait_drain("arst_fresh_drain", 100);

`ifdef PKT_ARB_CNT_EN
    // Per-source handshake counters
    do_reset();
    for (int k = 0; k < 5; k++) load_v(32'h3000_0000 + 32'(k));
    for (int k = 0; k < 2; k++) load_i(32'h4000_0000 + 32'(k));
    for (int k = 0; k < 3; k++) expect_word(1'b0, 32'h3000_0000 + 32'(k));
    expect_word(1'b1, 32'h4000_0000);
    expect_word(1'b0, 32'h3000_0003);
    expect_word(1'b0, 32'h3000_0004);
    expect_word(1'b1, 32'h4000_0001);
    wait_drain("cnt_drain", 80);
    check("cnt_vf", 64'(vf_cnt), 64'd5);
    check("cnt_if", 64'(if_cnt), 64'd2);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("cnt_vf_clr", 64'(vf_cnt), 64'd0);
    check("cnt_if_clr", 64'(if_cnt), 64'd0);
`endif

    step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
